// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one parity-framed byte transmitter among N_REQ sources.
// Latches the winner's byte, runs the start/finish handshake and pulses gnt/done/err.
// Optional per-byte abort timeout is compiled in with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned TIMEOUT_TICKS = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [N_REQ-1:0]   err,
   output logic               busy,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_finish,
   input  logic               tx_enable
);

   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   typedef logic [IdxW-1:0] idx_t;

   typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_t;

   state_t           stateQ, stateD;
   idx_t             ptrQ, ptrD;
   idx_t             idxQ, idxD;
   logic [N_REQ-1:0] gntQ, gntD;
   logic [N_REQ-1:0] doneQ, doneD;
   logic             txStartQ, txStartD;
   logic [7:0]       txDataQ, txDataD;
   logic [7:0]       reqByte [N_REQ];
   idx_t             cand;
   idx_t             selIdx;
   logic             selFound;
   idx_t             nextPtr;

   for (genvar i = 0; i < int'(N_REQ); i++) begin : gen_bytes
      assign reqByte[i] = req_data[8*i+7 -: 8];
   end

   // First pending requester at or above ptr, wrapping modulo N_REQ.
   always_comb begin
      selFound = 1'b0;
      selIdx   = '0;
      cand     = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         cand = idx_t'((int'(ptrQ) + k) % int'(N_REQ));
         if (!selFound && req[cand]) begin
            selFound = 1'b1;
            selIdx   = cand;
         end
      end
   end

   assign nextPtr = (idxQ == idx_t'(N_REQ - 1)) ? '0 : idxQ + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
   logic [7:0]       cntQ, cntD;
   logic [N_REQ-1:0] errQ, errD;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      stateD   = stateQ;
      ptrD     = ptrQ;
      idxD     = idxQ;
      gntD     = '0;
      doneD    = '0;
      txStartD = txStartQ;
      txDataD  = txDataQ;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cntD     = cntQ;
      errD     = '0;
`endif
      unique case (stateQ)
         StIdle: begin
            if (selFound) begin
               txDataD      = reqByte[selIdx];
               idxD         = selIdx;
               gntD[selIdx] = 1'b1;
               txStartD     = 1'b1;
               stateD       = StStart;
            end
         end
         StStart: begin
            // Transmitter pulls finish low once it has taken the byte.
            if (!tx_finish) begin
               txStartD = 1'b0;
               stateD   = StBusy;
            end
         end
         StBusy: begin
            if (tx_finish) begin
               doneD[idxQ] = 1'b1;
               ptrD        = nextPtr;
               stateD      = StDone;
            end
         end
         StDone: begin
            stateD = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
      if (stateQ == StIdle) begin
         cntD = '0;
      end else if (tx_enable && (((stateQ == StStart) && tx_finish) ||
                                 ((stateQ == StBusy) && !tx_finish))) begin
         // Only counts while the exit condition is absent, so finish beats timeout.
         cntD = cntQ + 8'd1;
         if (32'(cntD) >= TIMEOUT_TICKS) begin
            errD[idxQ] = 1'b1;
            txStartD   = 1'b0;
            ptrD       = nextPtr;
            stateD     = StIdle;
         end
      end
`endif
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ   <= StIdle;
         ptrQ     <= '0;
         idxQ     <= '0;
         gntQ     <= '0;
         doneQ    <= '0;
         txStartQ <= 1'b0;
         txDataQ  <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
         cntQ     <= '0;
         errQ     <= '0;
`endif
      end else begin
         stateQ   <= stateD;
         ptrQ     <= ptrD;
         idxQ     <= idxD;
         gntQ     <= gntD;
         doneQ    <= doneD;
         txStartQ <= txStartD;
         txDataQ  <= txDataD;
`ifdef UART_TX_ARB_TIMEOUT_EN
         cntQ     <= cntD;
         errQ     <= errD;
`endif
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   assign err = errQ;
`else
   // Without the timeout the baud tick and limit have no role here.
   logic unusedTimeout;
   assign unusedTimeout = tx_enable ^ (TIMEOUT_TICKS == 0);
   assign err = '0;
`endif

   assign gnt      = gntQ;
   assign done     = doneQ;
   assign busy     = (stateQ != StIdle);
   assign tx_start = txStartQ;
   assign tx_data  = txDataQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] reqData = '0;
   logic [3:0]  gnt, done, err;
   logic        busy, txStart;
   logic [7:0]  txData;
   logic        txFinish = 1'b1;
   logic        txEnable = 1'b0;
   logic        stuck = 1'b0;

   int nChecks = 0;
   int nErrors = 0;

   uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_TICKS(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (reqData),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .tx_start  (txStart),
      .tx_data   (txData),
      .tx_finish (txFinish),
      .tx_enable (txEnable)
   );

   always #5 clk = ~clk;

   // Transmitter model: tick every other clk; finish drops 3 ticks after start, rises 11 later.
   initial begin
      int mPhase = 0;
      int mCnt = 0;
      forever begin
         @(negedge clk);
         txEnable = ~txEnable;
         if (!rst_n || stuck) begin
            txFinish = 1'b1;
            mPhase   = 0;
            mCnt     = 0;
         end else if (txEnable) begin
            if (mPhase == 0) begin
               if (txStart) begin
                  mCnt++;
                  if (mCnt == 3) begin
                     txFinish = 1'b0;
                     mPhase   = 1;
                     mCnt     = 0;
                  end
               end else begin
                  mCnt = 0;
               end
            end else begin
               mCnt++;
               if (mCnt == 11) begin
                  txFinish = 1'b1;
                  mPhase   = 0;
                  mCnt     = 0;
               end
            end
         end
      end
   end

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      req   = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic waitGrant(input int expIdx, input logic [7:0] expData);
      int n;
      tick();
      n = 1;
      while (gnt == 0 && n < 50) begin
         tick();
         n++;
      end
      checkEq("gnt", 32'(gnt), 32'(1) << expIdx);
      checkEq("grantData", 32'(txData), 32'(expData));
      checkEq("startOnGrant", 32'(txStart), 32'd1);
      checkEq("busyOnGrant", 32'(busy), 32'd1);
   endtask

   task automatic waitDone(input int expIdx, input logic [7:0] expData);
      int n = 0;
      while (done == 0 && n < 200) begin
         tick();
         n++;
         if (gnt != 0) checkEq("gntDuringXfer", 32'(gnt), 32'd0);
         if (err != 0) checkEq("errDuringXfer", 32'(err), 32'd0);
         checkEq("dataStable", 32'(txData), 32'(expData));
      end
      checkEq("done", 32'(done), 32'(1) << expIdx);
      checkEq("busyInDone", 32'(busy), 32'd1);
      tick();
      checkEq("busyAfterDone", 32'(busy), 32'd0);
      checkEq("donePulse", 32'(done), 32'd0);
   endtask

   initial begin
      int n;
      int ticks;

      // Reset values
      tick();
      tick();
      checkEq("rstGnt", 32'(gnt), 32'd0);
      checkEq("rstDone", 32'(done), 32'd0);
      checkEq("rstErr", 32'(err), 32'd0);
      checkEq("rstBusy", 32'(busy), 32'd0);
      checkEq("rstStart", 32'(txStart), 32'd0);
      checkEq("rstData", 32'(txData), 32'd0);
      rst_n = 1'b1;
      tick();

      // Reset in the middle of BUSY
      reqData = 32'h0000_005A;
      req     = 4'b0001;
      waitGrant(0, 8'h5A);
      req = '0;
      n   = 0;
      while (!(busy && !txStart) && n < 50) begin
         tick();
         n++;
      end
      checkEq("reachBusy", 32'(busy && !txStart), 32'd1);
      rst_n = 1'b0;
      #1;
      checkEq("asyncGnt", 32'(gnt), 32'd0);
      checkEq("asyncDone", 32'(done), 32'd0);
      checkEq("asyncBusy", 32'(busy), 32'd0);
      checkEq("asyncStart", 32'(txStart), 32'd0);
      checkEq("asyncData", 32'(txData), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checkEq("noDoneAfterRst", 32'(done), 32'd0);
      req = 4'b0001;
      tick();
      checkEq("gntAfterRst", 32'(gnt), 32'b0001);
      req = '0;
      waitDone(0, 8'h5A);

      // Single byte on requester 1; tx_start must drop on the edge that sees finish low
      reqData = 32'h0000_A500;
      req     = 4'b0010;
      waitGrant(1, 8'hA5);
      req = '0;
      n   = 0;
      while (txFinish && n < 100) begin
         checkEq("startHeld", 32'(txStart), 32'd1);
         tick();
         n++;
      end
      checkEq("startFall", 32'(txStart), 32'd0);
      waitDone(1, 8'hA5);

      // Round-robin with all requesters held high
      applyReset();
      reqData = 32'h4433_2211;
      req     = 4'b1111;
      waitGrant(0, 8'h11);
      waitDone(0, 8'h11);
      waitGrant(1, 8'h22);
      waitDone(1, 8'h22);
      waitGrant(2, 8'h33);
      waitDone(2, 8'h33);
      waitGrant(3, 8'h44);
      waitDone(3, 8'h44);
      waitGrant(0, 8'h11);
      req = '0;
      waitDone(0, 8'h11);

      // Wrap and skip: move ptr to 2, then req=1011 -> 3, 0, 1
      applyReset();
      reqData = 32'hD4C3_B2A1;
      req     = 4'b0010;
      waitGrant(1, 8'hB2);
      req = '0;
      waitDone(1, 8'hB2);
      req = 4'b1011;
      waitGrant(3, 8'hD4);
      waitDone(3, 8'hD4);
      waitGrant(0, 8'hA1);
      waitDone(0, 8'hA1);
      waitGrant(1, 8'hB2);
      req = '0;
      waitDone(1, 8'hB2);

      // Data stability after grant (ptr is 2 here)
      reqData = 32'h0000_003C;
      req     = 4'b0001;
      waitGrant(0, 8'h3C);
      reqData[7:0] = 8'hFF;
      req          = '0;
      waitDone(0, 8'h3C);

      // Stuck transmitter (ptr is 1 here)
      stuck   = 1'b1;
      reqData = 32'h0000_6655;
      req     = 4'b0011;
      waitGrant(1, 8'h66);
      req = 4'b0001;
`ifdef UART_TX_ARB_TIMEOUT_EN
      n     = 0;
      ticks = 0;
      while (err == 0 && n < 200) begin
         tick();
         n++;
         if (txEnable) ticks++;
         if (done != 0) checkEq("doneOnTimeout", 32'(done), 32'd0);
      end
      checkEq("errPulse", 32'(err), 32'b0010);
      checkEq("timeoutTicks", 32'(ticks), 32'd32);
      checkEq("startAfterErr", 32'(txStart), 32'd0);
      checkEq("doneWithErr", 32'(done), 32'd0);
      stuck = 1'b0;
      waitGrant(0, 8'h55);
      req = '0;
      waitDone(0, 8'h55);
`else
      repeat (100) tick();
      checkEq("stuckBusy", 32'(busy), 32'd1);
      checkEq("stuckStart", 32'(txStart), 32'd1);
      checkEq("stuckData", 32'(txData), 32'h66);
      checkEq("stuckErr", 32'(err), 32'd0);
      checkEq("stuckDone", 32'(done), 32'd0);
      stuck = 1'b0;
      applyReset();
`endif

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
